result_pack_fifo: RTL

RESULT_PACK_FIFO -- requirements
Module: result_pack_fifo

---
 rtl/result_pack_pkg.sv | 12 +
 rtl/rp_mem.sv | 25 ++
 rtl/result_pack_fifo.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/result_pack_pkg.sv
// Shared types and constants for result_pack_fifo: occupancy-state enum and drop-counter width.
package result_pack_pkg;

  localparam int DROP_CNT_W = 16;

  typedef enum logic [1:0] {
    EMPTY   = 2'd0,
    PARTIAL = 2'd1,
    FULL    = 2'd2
  } occ_state_e;

endpackage

// File: rtl/rp_mem.sv
// Storage for result_pack_fifo: DEPTH x DW register array, synchronous write, asynchronous read.
module rp_mem #(
  parameter int DW    = 64,
  parameter int DEPTH = 4
) (
  input  logic                     clk_i,
  input  logic                     we_i,
  input  logic [$clog2(DEPTH)-1:0] waddr_i,
  input  logic [DW-1:0]            wdata_i,
  input  logic [$clog2(DEPTH)-1:0] raddr_i,
  output logic [DW-1:0]            rdata_o
);

  logic [DW-1:0] mem_q [DEPTH];

  // Data entries carry no reset; only the pointers decide what is valid.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/result_pack_fifo.sv
// First-word-fall-through FIFO packing {z,x} result pairs.
// Define RESULT_PACK_STATS_EN to build the saturating overflow-drop counter behind drop_cnt.
module result_pack_fifo
  import result_pack_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                     Clk,
  input  logic                     Rst,
  input  logic [WIDTH-1:0]         z,
  input  logic [WIDTH-1:0]         x,
  input  logic                     in_valid,
  output logic                     in_ready,
  output logic [2*WIDTH-1:0]       out_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [$clog2(DEPTH):0]   count,
  output logic [DROP_CNT_W-1:0]    drop_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  occ_state_e    state_q, state_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          in_ready_q, in_ready_d;
  logic          out_valid_q, out_valid_d;
  logic          wr_s;
  logic          rd_s;

  assign wr_s = in_valid && in_ready_q;
  assign rd_s = out_valid_q && out_ready;

  rp_mem #(
    .DW    (2*WIDTH),
    .DEPTH (DEPTH)
  ) u_mem (
    .clk_i   (Clk),
    .we_i    (wr_s),
    .waddr_i (wr_ptr_q),
    .wdata_i ({z, x}),
    .raddr_i (rd_ptr_q),
    .rdata_o (out_data)
  );

  // Next-state: occupancy FSM, pointers, count and the handshake flags derived from the new state.
  always_comb begin
    state_d  = state_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;

    if (wr_s) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end

    if (rd_s) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end

    case ({wr_s, rd_s})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase

    case (state_q)
      EMPTY: begin
        if (wr_s) begin
          state_d = PARTIAL;
        end else begin
          state_d = EMPTY;
        end
      end
      PARTIAL: begin
        if (wr_s && !rd_s && (count_q == CW'(DEPTH - 1))) begin
          state_d = FULL;
        end else if (rd_s && !wr_s && (count_q == CW'(1))) begin
          state_d = EMPTY;
        end else begin
          state_d = PARTIAL;
        end
      end
      FULL: begin
        if (rd_s) begin
          state_d = PARTIAL;
        end else begin
          state_d = FULL;
        end
      end
      default: state_d = EMPTY;
    endcase

    in_ready_d  = (state_d != FULL);
    out_valid_d = (state_d != EMPTY);
  end

  // Control state register; reset drops every entry without touching storage.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state_q     <= EMPTY;
      wr_ptr_q    <= {AW{1'b0}};
      rd_ptr_q    <= {AW{1'b0}};
      count_q     <= {CW{1'b0}};
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign count     = count_q;

`ifdef RESULT_PACK_STATS_EN
  logic [DROP_CNT_W-1:0] drop_q, drop_d;

  // Saturating count of cycles where a result was offered but could not be stored.
  always_comb begin
    drop_d = drop_q;
    if (in_valid && !in_ready_q && (drop_q != {DROP_CNT_W{1'b1}})) begin
      drop_d = drop_q + DROP_CNT_W'(1);
    end else begin
      drop_d = drop_q;
    end
  end

  // Drop counter register.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      drop_q <= {DROP_CNT_W{1'b0}};
    end else begin
      drop_q <= drop_d;
    end
  end

  assign drop_cnt = drop_q;
`else
  assign drop_cnt = {DROP_CNT_W{1'b0}};
`endif

endmodule
